conv_window_sequencer: RTL and testbench

- Sequences the 16-channel 5x5 window FIFO for one convolution layer.
- Walks the zero-padded input frame in raster order, one 16-channel group at a time. For each position it either fetches a 16-pixel word from feature-map memory or injects a zero padding word.
- Drives the FIFO's write-enable, zero-buffering, end-of-layer and size configuration inputs, then drains the FIFO until it reports the window done.
- Sits between the layer controller, which issues start and config, and the window FIFO plus its source memory.

---
 rtl/conv_seq_pkg.sv | 18 +
 rtl/conv_window_sequencer_if.sv | 17 +
 rtl/conv_window_sequencer_pad_raster_counter.sv | 35 +++
 rtl/conv_window_sequencer.sv | 115 +++++++++++
 tb/tb_conv_window_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state encoding, widths and config helpers for the window sequencer
package conv_seq_pkg;
  localparam int ROW_W = 7;
  localparam int WIN_W = 12;
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, DRAIN, NEXT} state_t;
  function automatic logic cfg_is_zero(input logic [ROW_W-1:0] w, input logic [ROW_W-1:0] h,
                                       input logic grp_nz);
    return w == '0 || h == '0 || !grp_nz;
  endfunction
  function automatic logic [ROW_W-1:0] ceil_half(input logic [ROW_W-1:0] x);
    return ROW_W'(({1'b0, x} + (ROW_W+1)'(1)) >> 1);
  endfunction
  function automatic logic [WIN_W-1:0] window_size(input logic [ROW_W-1:0] w,
                                                    input logic [ROW_W-1:0] h, input logic stride);
    return WIN_W'(stride ? {{ROW_W{1'b0}}, ceil_half(w)} * {{ROW_W{1'b0}}, ceil_half(h)}
                         : {{ROW_W{1'b0}}, w} * {{ROW_W{1'b0}}, h});
  endfunction
endpackage

// File: rtl/conv_window_sequencer_if.sv
// conv_window_sequencer_if: memory-read and window-FIFO side of the sequencer
interface conv_window_sequencer_if import conv_seq_pkg::*; #(parameter int ADDR_W = 16) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              fifo_wr_en;
  logic              fifo_zero_buffering;
  logic              fifo_ex_window_done;
  logic [ROW_W-1:0]  fifo_row_size;
  logic [WIN_W-1:0]  fifo_full_window_size;
  logic              depth_window_done;
  modport master(output mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_zero_buffering,
                 fifo_ex_window_done, fifo_row_size, fifo_full_window_size,
                 input depth_window_done);
  modport slave(input mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_zero_buffering,
                fifo_ex_window_done, fifo_row_size, fifo_full_window_size,
                output depth_window_done);
endinterface

// File: rtl/conv_window_sequencer_pad_raster_counter.sv
// pad_raster_counter: raster walk over the zero-padded frame with pad classification
module pad_raster_counter import conv_seq_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [ROW_W-1:0] row_size,
  input  logic [ROW_W-1:0] col_size,
  input  logic [1:0]       pad,
  output logic             last,
  output logic             is_pad
);
  logic [ROW_W:0] r_q, r_d, c_q, c_d, wp, hp, p_ext;
  logic eol;
  always_comb begin
    p_ext = {{(ROW_W-1){1'b0}}, pad};
    wp = {1'b0, row_size} + (p_ext << 1);
    hp = {1'b0, col_size} + (p_ext << 1);
    eol = c_q == wp - (ROW_W+1)'(1);
    last = eol && r_q == hp - (ROW_W+1)'(1);
    is_pad = r_q < p_ext || r_q >= {1'b0, col_size} + p_ext ||
             c_q < p_ext || c_q >= {1'b0, row_size} + p_ext;
    c_d = clr ? '0 : adv ? (eol ? '0 : c_q + (ROW_W+1)'(1)) : c_q;
    r_d = clr ? '0 : (adv && eol) ? (last ? '0 : r_q + (ROW_W+1)'(1)) : r_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks the padded frame per depth group, feeding the 5x5 window FIFO
module conv_window_sequencer import conv_seq_pkg::*; #(
  parameter int ADDR_W    = 16,
  parameter int GRP_W     = 6,
  parameter int DRAIN_MAX = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_W-1:0]      cfg_row_size,
  input  logic [ROW_W-1:0]      cfg_col_size,
  input  logic [1:0]            cfg_pad,
  input  logic                  cfg_stride,
  input  logic [GRP_W-1:0]      cfg_depth_groups,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic                  pause,
  conv_window_sequencer_if.master bus,
  output logic [GRP_W-1:0]      group_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0] w_q, w_d, h_q, h_d;
  logic [1:0] p_q, p_d;
  logic [GRP_W-1:0] grp_q, grp_d, gcnt_q, gcnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic flag_q, flag_d, wr_q, wr_d, zb_q, zb_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic accept, zero, slot, seen, last, is_pad, clr, drain_wr;
  pad_raster_counter u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .adv(slot), .row_size(w_q), .col_size(h_q),
    .pad(p_q), .last(last), .is_pad(is_pad)
  );
  always_comb begin
    accept = state_q == IDLE && start && !done_q;
    zero = cfg_is_zero(cfg_row_size, cfg_col_size, |cfg_depth_groups);
    slot = state_q == FILL && !pause;
    seen = flag_q || bus.depth_window_done;
    state_d = state_q;
    addr_d = (slot && !is_pad) ? addr_q + ADDR_W'(1) : addr_q;
    {w_d, h_d, p_d, gcnt_d, win_d} = {w_q, h_q, p_q, gcnt_q, win_q};
    grp_d = grp_q;
    dcnt_d = dcnt_q;
    err_d = err_q;
    done_d = 1'b0;
    clr = 1'b0;
    wr_d = slot;
    zb_d = slot && is_pad;
    flag_d = (state_q == FILL || state_q == FLUSH || state_q == DRAIN) ? seen : 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        {w_d, h_d, p_d, gcnt_d} = {cfg_row_size, cfg_col_size, cfg_pad, cfg_depth_groups};
        win_d = window_size(cfg_row_size, cfg_col_size, cfg_stride);
        addr_d = cfg_base_addr;
        grp_d = '0;
        clr = 1'b1;
        err_d = zero;
        done_d = zero;
        state_d = zero ? IDLE : FILL;
      end
      FILL: state_d = (slot && last) ? FLUSH : FILL;
      FLUSH: begin
        dcnt_d = '0;
        state_d = seen ? NEXT : DRAIN;
      end
      DRAIN: if (seen) state_d = NEXT;
      else if (!pause) begin
        dcnt_d = dcnt_q + CNT_W'(1);
        // a window-done that never comes must not wedge the layer
        if (dcnt_q == CNT_W'(DRAIN_MAX - 1)) begin
          err_d = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        clr = 1'b1;
        done_d = grp_q == gcnt_q - GRP_W'(1);
        grp_d = done_d ? grp_q : grp_q + GRP_W'(1);
        state_d = done_d ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE || (accept && zero);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {addr_q, w_q, h_q, p_q, grp_q, gcnt_q, win_q, dcnt_q} <= '0;
      {flag_q, wr_q, zb_q, busy_q, done_q, err_q} <= '0;
    end else begin
      state_q <= state_d;
      {addr_q, w_q, h_q, p_q, grp_q, gcnt_q, win_q, dcnt_q} <=
        {addr_d, w_d, h_d, p_d, grp_d, gcnt_d, win_d, dcnt_d};
      {flag_q, wr_q, zb_q, busy_q, done_q, err_q} <= {flag_d, wr_d, zb_d, busy_d, done_d, err_d};
    end
  end
  always_comb begin
    drain_wr = state_q == DRAIN && !pause;
    bus.mem_rd_en = slot && !is_pad;
    bus.mem_rd_addr = addr_q;
    bus.fifo_wr_en = wr_q || drain_wr;
    bus.fifo_zero_buffering = zb_q || drain_wr;
    bus.fifo_ex_window_done = state_q == FLUSH;
    bus.fifo_row_size = w_q;
    bus.fifo_full_window_size = win_q;
    group_idx = grp_q;
    busy = busy_q;
    done = done_q;
    err = err_q;
  end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: table-driven layers with a write scoreboard plus hand-timed corner cases
module tb_conv_window_sequencer;
  import conv_seq_pkg::*;
  typedef struct {int w, h, p, s, g, base, dly, win, err, reads;} vec_t;
  typedef struct {logic zb; logic [15:0] addr; logic ex; logic [5:0] grp;} ent_t;
  logic clk = 0, rst = 1, start = 0, pause = 0, cfg_stride = 0;
  logic [6:0] cfg_row_size = 0, cfg_col_size = 0;
  logic [1:0] cfg_pad = 0;
  logic [5:0] cfg_depth_groups = 0, group_idx;
  logic [15:0] cfg_base_addr = 0;
  logic busy, done, err;
  int checks = 0, errors = 0, reads = 0, drains = 0, exs = 0;
  ent_t exp_q[$];
  ent_t e;
  logic in_drain = 0, prev_rd = 0;
  logic [15:0] prev_addr = 0;
  logic [5:0] last_grp = 0;
  vec_t vecs[9];
  vec_t hv;
  conv_window_sequencer_if #(.ADDR_W(16)) bus ();
  conv_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_row_size(cfg_row_size), .cfg_col_size(cfg_col_size),
    .cfg_pad(cfg_pad), .cfg_stride(cfg_stride), .cfg_depth_groups(cfg_depth_groups),
    .cfg_base_addr(cfg_base_addr), .pause(pause), .bus(bus), .group_idx(group_idx),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus.fifo_wr_en && in_drain) begin
      drains++;
      chk("drain_zero", bus.fifo_zero_buffering, 1);
    end else if (bus.fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: fifo_wr_en=1 with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_zero", bus.fifo_zero_buffering, e.zb);
        chk("wr_read_prev", prev_rd, !e.zb);
        if (!e.zb) chk("wr_addr", prev_addr, e.addr);
        chk("wr_ex", bus.fifo_ex_window_done, e.ex);
        chk("wr_grp", group_idx, e.grp);
      end
    end
    if (bus.fifo_ex_window_done) begin
      exs++;
      in_drain = 1;
    end
    if (in_drain && (group_idx != last_grp || !busy)) in_drain = 0;
    if (bus.mem_rd_en) reads++;
    prev_rd = bus.mem_rd_en;
    prev_addr = bus.mem_rd_addr;
    last_grp = group_idx;
    if (rst) begin
      exp_q.delete();
      in_drain = 0;
    end
  end
  task automatic push_model(input vec_t v);
    int a = v.base;
    if (v.w == 0 || v.h == 0 || v.g == 0) return;
    for (int g = 0; g < v.g; g++)
      for (int r = 0; r < v.h + 2 * v.p; r++)
        for (int c = 0; c < v.w + 2 * v.p; c++) begin
          logic pad;
          pad = r < v.p || r >= v.h + v.p || c < v.p || c >= v.w + v.p;
          exp_q.push_back('{pad, pad ? 16'h0 : 16'(a),
                            r == v.h + 2 * v.p - 1 && c == v.w + 2 * v.p - 1, 6'(g)});
          if (!pad) a++;
        end
  endtask
  task automatic launch(input vec_t v);
    bus.depth_window_done = 1;
    step();
    bus.depth_window_done = 0;
    push_model(v);
    reads = 0;
    drains = 0;
    exs = 0;
    cfg_row_size = 7'(v.w);
    cfg_col_size = 7'(v.h);
    cfg_pad = 2'(v.p);
    cfg_stride = v.s[0];
    cfg_depth_groups = 6'(v.g);
    cfg_base_addr = 16'(v.base);
    start = 1;
    step();
    start = 0;
  endtask
  task automatic complete(input vec_t v);
    int n;
    for (int g = 0; g < v.g; g++) begin
      n = 0;
      while (!bus.fifo_ex_window_done && n < 20000) begin step(); n++; end
      chk("ex_wait", bus.fifo_ex_window_done, 1);
      if (!bus.fifo_ex_window_done) break;
      if (v.dly >= 0) begin
        repeat (v.dly + 1) step();
        bus.depth_window_done = 1;
        step();
        bus.depth_window_done = 0;
        if (g == v.g - 1) begin
          chk("next_done", done, 0);
          chk("next_busy", busy, 1);
          step();
          chk("done_after_next", done, 1);
        end
      end
    end
    n = 0;
    while (!done && n < 3000) begin step(); n++; end
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("win_size", bus.fifo_full_window_size, v.win);
    chk("row_size", bus.fifo_row_size, v.w);
    chk("err", err, v.err);
    chk("reads", reads, v.reads);
    chk("drain_writes", drains, v.dly >= 0 ? v.g * (v.dly + 1) : (v.dly == -1 ? v.g * 1024 : 0));
    chk("ex_pulses", exs, v.g);
    chk("sb_left", exp_q.size(), 0);
  endtask
  task automatic run_vec(input vec_t v);
    launch(v);
    if (v.dly == -2) begin
      repeat (3) step();
      bus.depth_window_done = 1;
      step();
      bus.depth_window_done = 0;
    end
    complete(v);
  endtask
  initial begin
    // {w, h, p, stride, groups, base, drain delay (-1 never, -2 in FILL), win, err, reads}
    vecs[0] = '{4, 4, 1, 0, 1, 'h100, 5, 16, 0, 16};
    vecs[1] = '{4, 4, 0, 0, 3, 'h000, 2, 16, 0, 48};
    vecs[2] = '{5, 5, 0, 1, 1, 'h020, 0, 9, 0, 25};
    vecs[3] = '{3, 2, 2, 0, 2, 'h040, 1, 6, 0, 12};
    vecs[4] = '{7, 3, 1, 1, 1, 'h300, 3, 8, 0, 21};
    vecs[5] = '{100, 50, 0, 0, 1, 'h1000, 0, 904, 0, 5000};
    vecs[6] = '{4, 4, 1, 0, 1, 'h500, -1, 16, 1, 16};
    vecs[7] = '{5, 4, 0, 0, 1, 'h600, -2, 20, 0, 20};
    vecs[8] = '{6, 6, 2, 1, 2, 'h700, 4, 9, 0, 72};
    bus.depth_window_done = 0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr", bus.fifo_wr_en, 0);
    chk("rst_rd", bus.mem_rd_en, 0);
    chk("rst_win", bus.fifo_full_window_size, 0);
    rst = 0;
    hv = '{4, 4, 0, 0, 1, 'h80, 1, 16, 0, 16};
    launch(hv);
    chk("c1_rd", bus.mem_rd_en, 1);
    chk("c1_addr", bus.mem_rd_addr, 'h80);
    chk("c1_wr", bus.fifo_wr_en, 0);
    chk("c1_busy", busy, 1);
    step();
    chk("c2_wr", bus.fifo_wr_en, 1);
    chk("c2_zb", bus.fifo_zero_buffering, 0);
    chk("c2_addr", bus.mem_rd_addr, 'h81);
    step();
    pause = 1;
    #1;
    chk("p0_rd", bus.mem_rd_en, 0);
    chk("p0_trailing_wr", bus.fifo_wr_en, 1);
    step();
    chk("p1_rd", bus.mem_rd_en, 0);
    chk("p1_wr", bus.fifo_wr_en, 0);
    step();
    chk("p2_rd", bus.mem_rd_en, 0);
    chk("p2_wr", bus.fifo_wr_en, 0);
    step();
    pause = 0;
    #1;
    chk("resume_rd", bus.mem_rd_en, 1);
    chk("resume_addr", bus.mem_rd_addr, 'h82);
    complete(hv);
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    hv = '{0, 4, 1, 0, 1, 'h900, 0, 0, 1, 0};
    launch(hv);
    chk("zero_done", done, 1);
    chk("zero_err", err, 1);
    chk("zero_busy", busy, 1);
    chk("zero_wr", bus.fifo_wr_en, 0);
    chk("zero_win", bus.fifo_full_window_size, 0);
    cfg_row_size = 4;
    start = 1;
    step();
    start = 0;
    chk("start_on_done_busy", busy, 0);
    chk("zero_done_pulse", done, 0);
    repeat (4) step();
    chk("ignored_start_idle", busy, 0);
    chk("zero_reads", reads, 0);
    hv = '{4, 4, 0, 0, 2, 'h50, 0, 16, 0, 32};
    launch(hv);
    repeat (5) step();
    rst = 1;
    step();
    chk("mid_rst_rd", bus.mem_rd_en, 0);
    chk("mid_rst_addr", bus.mem_rd_addr, 0);
    chk("mid_rst_wr", bus.fifo_wr_en, 0);
    chk("mid_rst_zb", bus.fifo_zero_buffering, 0);
    chk("mid_rst_ex", bus.fifo_ex_window_done, 0);
    chk("mid_rst_row", bus.fifo_row_size, 0);
    chk("mid_rst_win", bus.fifo_full_window_size, 0);
    chk("mid_rst_grp", group_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 0;
    run_vec('{4, 4, 0, 0, 1, 'h50, 0, 16, 0, 16});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
